mag_window_stats: RTL
=====================

Name: mag_window_stats

Overview:
- Downstream consumer of the per-cycle magnitude sample, the 8-bit sqrt(x^2+y^2) result.
- Collects samples over a fixed window of 2^LOG2_WIN valid samples.
- At window end it publishes the maximum, minimum and average, and raises a one-cycle done pulse.
- Accumulators then restart for the next window, with no dead cycle.

Parameters:
- DATA_W, 8: magnitude sample width.
- LOG2_WIN, 3: log2 of window length. Window = 8 samples. Legal range 1..6.
- THRESH, 8'd200: alarm threshold. Used only with MAG_ALARM_EN.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  block enable; when low, all state holds
- clear  input  1  synchronous restart of the current window (and the alarm)
- mag_in  input  DATA_W  magnitude sample
- mag_valid  input  1  mag_in is valid this cycle
- max_out  output  DATA_W  maximum of the last completed window
- min_out  output  DATA_W  minimum of the last completed window
- avg_out  output  DATA_W  floor(sum/2^LOG2_WIN) of the last completed window
- stats_valid  output  1  one-cycle pulse when new results are published
- sample_cnt  output  LOG2_WIN  samples accepted in the current window
- alarm  output  1  sticky over-threshold flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - max_out, min_out, avg_out, stats_valid, sample_cnt and alarm all = 0.
  - Internal sum = 0, run_max = 0, run_min = all-ones, state = FILL.
- Sample acceptance: only on a cycle with ena=1, mag_valid=1 and clear=0.
- ena=0: all registers hold, including the outputs. stats_valid is forced to 0 that cycle.
- Internal accumulators:
  - sum is DATA_W+LOG2_WIN bits wide, so it cannot overflow.
  - run_max is DATA_W bits, initial value 0.
  - run_min is DATA_W bits, initial value all-ones.
- Per accepted sample:
  - sum += mag_in.
  - run_max = max(run_max, mag_in).
  - run_min = min(run_min, mag_in).
  - sample_cnt += 1.
- States:
  - FILL: accepting samples.
  - PUBLISH: not a separate cycle; it is folded into the last-sample edge.
- Last sample (accepted sample with sample_cnt = 2^LOG2_WIN-1). On that clock edge:
  - max_out and min_out take the maximum/minimum including this sample.
  - avg_out = (sum + mag_in) >> LOG2_WIN, truncated, never rounded.
  - stats_valid = 1 for exactly the next cycle.
  - sum resets to 0, run_max to 0, run_min to all-ones.
  - sample_cnt wraps to 0.
- Latency: results are visible one cycle after the edge on which the final sample is sampled.
- Back-to-back windows: a sample accepted in the cycle where stats_valid=1 counts as sample 0 of the next window. No samples are lost.
- Gaps: mag_valid=0 cycles do not advance the window. Windows are counted in samples, not cycles.
- Outputs max_out, min_out and avg_out hold between publications. Downstream may read them at any time.
- clear=1 (with ena=1):
  - sum, run_max, run_min and sample_cnt return to their reset values.
  - The published outputs are unchanged. stats_valid = 0 that cycle.
  - clear with mag_valid in the same cycle: clear wins and the sample is dropped.
- Reset mid-window: the partial window is discarded and all outputs return to 0.
- Equal samples: max = min = avg = that value.

Optional Feature:
- Macro: MAG_ALARM_EN.
- When defined:
  - alarm is set on the edge after any accepted sample with mag_in > THRESH (strictly greater).
  - It stays set across windows until clear=1 (with ena=1) or reset.
  - A clear in the same cycle as an over-threshold sample leaves alarm = 0, because that sample is dropped.
- When undefined: alarm is tied to 0 and no comparator or flag register is built.

Test Plan:
- Samples 1,2,...,8 on consecutive cycles (LOG2_WIN=3) -> one cycle after sample 8: stats_valid=1, max_out=8, min_out=1, avg_out=4 (36>>3). sample_cnt reads 0.
- Eight samples of 255 -> max=min=avg=255, no overflow (sum=2040). Next window 0,0,0,0,0,0,0,7 -> max=7, min=0, avg=0, and the previous outputs held until that publication.
- Samples 10,20,30 with mag_valid=0 gaps of 3 cycles, plus ena=0 for 5 cycles mid-stream -> sample_cnt=3, no stats_valid, outputs unchanged. Continue with 40..80 in steps of 10 -> max=80, min=10, avg=45.
- Four samples, then clear=1 together with mag_valid=1 and mag_in=99 -> sample_cnt=0 and 99 is dropped. Eight samples of 5 -> avg_out=5, max_out=5.
- rst_n pulled low asynchronously after 6 samples -> all outputs 0 immediately. After release, a full window of 3s -> stats equal 3.
- MAG_ALARM_EN, THRESH=200: samples 200 -> alarm stays 0; sample 201 -> alarm=1 next cycle and persists through the window publish; clear -> alarm=0. Without the macro, alarm stays 0 throughout.

Source files
------------

// File: rtl/mag_window_stats_if.sv
// rtl/mag_window_stats_if.sv - magnitude sample in / window statistics out bundle
interface mag_window_stats_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] mag_in;
    logic              mag_valid;
    logic [DATA_W-1:0] max_out;
    logic [DATA_W-1:0] min_out;
    logic [DATA_W-1:0] avg_out;
    logic              stats_valid;

    modport master (
        output mag_in, mag_valid,
        input  max_out, min_out, avg_out, stats_valid
    );

    modport slave (
        input  mag_in, mag_valid,
        output max_out, min_out, avg_out, stats_valid
    );
endinterface

// File: rtl/mag_window_stats.sv
// rtl/mag_window_stats.sv - max/min/avg over 2^LOG2_WIN magnitude samples; MAG_ALARM_EN adds the alarm flag
module mag_window_stats #(
    parameter int                DATA_W   = 8,
    parameter int                LOG2_WIN = 3,
    parameter logic [DATA_W-1:0] THRESH   = 8'd200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clear,
    mag_window_stats_if.slave    bus,
    output logic [LOG2_WIN-1:0]  sample_cnt,
    output logic                 alarm
);
    localparam int SUM_W = DATA_W + LOG2_WIN;

    typedef enum logic {FILL, PUBLISH} state_t;

    state_t              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   run_max_q, run_max_d;
    logic [DATA_W-1:0]   run_min_q, run_min_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   avg_q, avg_d;

    logic              accept;
    logic              last;
    logic [SUM_W-1:0]  sum_acc;
    logic [DATA_W-1:0] max_acc;
    logic [DATA_W-1:0] min_acc;

    assign accept  = ena & bus.mag_valid & ~clear;
    assign last    = accept & (cnt_q == {LOG2_WIN{1'b1}});
    assign sum_acc = sum_q + SUM_W'(bus.mag_in);
    assign max_acc = (bus.mag_in > run_max_q) ? bus.mag_in : run_max_q;
    assign min_acc = (bus.mag_in < run_min_q) ? bus.mag_in : run_min_q;

    // PUBLISH marks the single cycle after the last-sample edge; samples are still accepted in it.
    always_comb begin
        state_d   = FILL;
        sum_d     = sum_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        avg_d     = avg_q;
        if (ena) begin
            if (clear) begin
                sum_d     = '0;
                run_max_d = '0;
                run_min_d = '1;
                cnt_d     = '0;
            end else if (last) begin
                state_d   = PUBLISH;
                max_d     = max_acc;
                min_d     = min_acc;
                avg_d     = sum_acc[SUM_W-1:LOG2_WIN];
                sum_d     = '0;
                run_max_d = '0;
                run_min_d = '1;
                cnt_d     = '0;
            end else if (accept) begin
                sum_d     = sum_acc;
                run_max_d = max_acc;
                run_min_d = min_acc;
                cnt_d     = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            sum_q     <= '0;
            run_max_q <= '0;
            run_min_q <= '1;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            avg_q     <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            avg_q     <= avg_d;
        end
    end

    assign bus.max_out     = max_q;
    assign bus.min_out     = min_q;
    assign bus.avg_out     = avg_q;
    assign bus.stats_valid = (state_q == PUBLISH) & ena & ~clear;
    assign sample_cnt      = cnt_q;

`ifdef MAG_ALARM_EN
    logic alarm_q, alarm_d;

    // Sticky until an explicit clear; a sample dropped by clear never raises it.
    always_comb begin
        alarm_d = alarm_q;
        if (ena) begin
            if (clear) begin
                alarm_d = 1'b0;
            end else if (accept && (bus.mag_in > THRESH)) begin
                alarm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif
endmodule
